gray_tick_gen: RTL

GRAY_TICK_GEN -- requirements
Module: gray_tick_gen

---
 rtl/gray_pkg.sv | 12 +
 rtl/btn_debounce.sv | 47 ++++
 rtl/gray_tick_gen.sv | 82 ++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared FSM state type and default timing constants for gray_tick_gen
package gray_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        PAUSE = 1'b1
    } state_t;

    localparam int unsigned DEF_DIV        = 100_000_000;
    localparam int unsigned DEF_DEB_CYCLES = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, counting debouncer and rising-edge press pulse
module btn_debounce
    import gray_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The level flips on the DEB_CYCLES-th consecutive differing sample; any agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != level) begin
                if (cnt == LAST) begin
                    level <= sync2;
                    press <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/gray_tick_gen.sv
// rtl/gray_tick_gen.sv - run/pause tick prescaler for a Gray counter; GRAY_TICK_STEP_EN adds single-step
module gray_tick_gen
    import gray_pkg::*;
#(
    parameter int unsigned DIV        = DEF_DIV,
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_run,
    input  logic btn_step,
    output logic clk_en,
    output logic running
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_nx;
    logic          en_nx;
    logic          run_press;
    logic          step_press;
    logic          unused_run_level;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_deb (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_run),
        .level  (unused_run_level),
        .press  (run_press)
    );

`ifdef GRAY_TICK_STEP_EN
    logic unused_step_level;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_step),
        .level  (unused_step_level),
        .press  (step_press)
    );
`else
    logic unused_step;
    assign unused_step = btn_step;
    assign step_press  = 1'b0;
`endif

    // clk_en is computed from next-state values so the registered pulse lands in the cycle pcnt == DIV-1.
    always_comb begin
        state_nx = state;
        pcnt_nx  = '0;
        en_nx    = 1'b0;
        if (run_press) begin
            state_nx = (state == RUN) ? PAUSE : RUN;
        end
        if (state == RUN && state_nx == RUN) begin
            pcnt_nx = (pcnt == LAST) ? '0 : pcnt + PW'(1);
            en_nx   = (pcnt_nx == LAST);
        end else if (state == PAUSE && state_nx == PAUSE) begin
            en_nx = step_press;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            pcnt   <= '0;
            clk_en <= 1'b0;
        end else begin
            state  <= state_nx;
            pcnt   <= pcnt_nx;
            clk_en <= en_nx;
        end
    end

    assign running = (state == RUN);

endmodule
